// File: rtl/frequency_analyzer_sequencer_if.sv
// Control/analyzer-side bundle of the frequency analyzer sequencer.
// master: control registers (drive enable/oneshot, observe pulses).
// slave:  the sequencer itself.
// FREQ_ANALYZER_SEQ_RUNTIME_WINDOW_EN adds window_ticks/window_load.
interface frequency_analyzer_sequencer_if #(
    parameter int unsigned CHANNELS      = 2,
    parameter int unsigned COUNTER_WIDTH = 32
);
    localparam int unsigned IdxWidth = $clog2(CHANNELS);

    logic                     enable;
    logic                     oneshot;
`ifdef FREQ_ANALYZER_SEQ_RUNTIME_WINDOW_EN
    logic [COUNTER_WIDTH-1:0] window_ticks;
    logic                     window_load;
`endif
    logic [CHANNELS-1:0]      start_analyzer;
    logic [CHANNELS-1:0]      stop_analyzer;
    logic [IdxWidth-1:0]      active_channel;
    logic                     busy;
    logic                     done;

`ifdef FREQ_ANALYZER_SEQ_RUNTIME_WINDOW_EN
    modport master (
        output enable, oneshot, window_ticks, window_load,
        input  start_analyzer, stop_analyzer, active_channel, busy, done
    );
    modport slave (
        input  enable, oneshot, window_ticks, window_load,
        output start_analyzer, stop_analyzer, active_channel, busy, done
    );
`else
    modport master (
        output enable, oneshot,
        input  start_analyzer, stop_analyzer, active_channel, busy, done
    );
    modport slave (
        input  enable, oneshot,
        output start_analyzer, stop_analyzer, active_channel, busy, done
    );
`endif
endinterface

// File: rtl/frequency_analyzer_sequencer.sv
// Round-robin start/stop sequencer for an N-channel frequency analyzer bank.
// Optional runtime window length: FREQ_ANALYZER_SEQ_RUNTIME_WINDOW_EN.
module frequency_analyzer_sequencer #(
    parameter int unsigned CHANNELS      = 2,
    parameter int unsigned CLOCK         = 100000000,
    parameter int unsigned FREQUENCY     = 2000,
    parameter int unsigned PULSE_WIDTH   = 20,
    parameter int unsigned COUNTER_WIDTH = 32
) (
    input logic                           clock,
    input logic                           reset,
    frequency_analyzer_sequencer_if.slave bus
);
    localparam int unsigned IdxWidth = $clog2(CHANNELS);
    localparam logic [COUNTER_WIDTH-1:0] WindowDefault = COUNTER_WIDTH'(CLOCK / FREQUENCY);
    localparam logic [COUNTER_WIDTH-1:0] PulseLen      = COUNTER_WIDTH'(PULSE_WIDTH);
    localparam logic [COUNTER_WIDTH-1:0] One           = COUNTER_WIDTH'(1);
    localparam logic [IdxWidth-1:0]      LastChannel   = IdxWidth'(CHANNELS - 1);

    typedef enum logic [1:0] {StIdle, StRun, StStopping} state_e;

    state_e                   state_q, state_d;
    logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
    logic [COUNTER_WIDTH-1:0] win_q, win_d;
    logic [IdxWidth-1:0]      k_q, k_d;
    logic [IdxWidth-1:0]      stop_k_q, stop_k_d;
    logic                     start_vld_q, start_vld_d;
    logic                     stop_vld_q, stop_vld_d;
    logic                     oneshot_q, oneshot_d;
    logic [CHANNELS-1:0]      start_q, start_d;
    logic [CHANNELS-1:0]      stop_q, stop_d;
    logic                     done_q, done_d;
    logic                     busy_q, busy_d;
    logic                     boundary;
`ifdef FREQ_ANALYZER_SEQ_RUNTIME_WINDOW_EN
    localparam logic [COUNTER_WIDTH-1:0] WindowMin = COUNTER_WIDTH'(PULSE_WIDTH + 1);
    logic [COUNTER_WIDTH-1:0] pend_q, pend_d;
    logic                     pend_vld_q, pend_vld_d;
    logic [COUNTER_WIDTH-1:0] load_val;
`endif

    // Next-state: window counter, channel rotation, stop sequencing, outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        win_d       = win_q;
        k_d         = k_q;
        stop_k_d    = stop_k_q;
        start_vld_d = start_vld_q;
        stop_vld_d  = stop_vld_q;
        oneshot_d   = oneshot_q;
        done_d      = 1'b0;
        boundary    = (cnt_q == (win_q - One));
`ifdef FREQ_ANALYZER_SEQ_RUNTIME_WINDOW_EN
        pend_d      = pend_q;
        pend_vld_d  = pend_vld_q;
        load_val    = (bus.window_ticks < WindowMin) ? WindowMin : bus.window_ticks;
`endif
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (bus.enable) begin
                    state_d     = StRun;
                    k_d         = '0;
                    oneshot_d   = bus.oneshot;
                    start_vld_d = 1'b1;
                    stop_vld_d  = 1'b0;
                end
            end
            StRun: begin
                // A boundary takes priority over enable dropping on the same edge.
                if (boundary) begin
                    cnt_d      = '0;
                    stop_k_d   = k_q;
                    stop_vld_d = 1'b1;
                    if (oneshot_q && (k_q == LastChannel)) begin
                        state_d     = StStopping;
                        start_vld_d = 1'b0;
                    end else begin
                        k_d         = (k_q == LastChannel) ? '0 : k_q + IdxWidth'(1);
                        start_vld_d = 1'b1;
                    end
`ifdef FREQ_ANALYZER_SEQ_RUNTIME_WINDOW_EN
                    if (pend_vld_q) begin
                        win_d      = pend_q;
                        pend_vld_d = 1'b0;
                    end
`endif
                end else if (!bus.enable) begin
                    state_d     = StStopping;
                    cnt_d       = '0;
                    stop_k_d    = k_q;
                    stop_vld_d  = 1'b1;
                    start_vld_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + One;
                end
            end
            StStopping: begin
                if (cnt_q == (PulseLen - One)) begin
                    state_d     = StIdle;
                    cnt_d       = '0;
                    done_d      = 1'b1;
                    start_vld_d = 1'b0;
                    stop_vld_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + One;
                end
            end
            default: state_d = StIdle;
        endcase
`ifdef FREQ_ANALYZER_SEQ_RUNTIME_WINDOW_EN
        // Idle applies a load at once; otherwise it waits for the next boundary.
        if (bus.window_load) begin
            if (state_q == StIdle) begin
                win_d      = load_val;
                pend_vld_d = 1'b0;
            end else begin
                pend_d     = load_val;
                pend_vld_d = 1'b1;
            end
        end
`endif
        start_d = '0;
        stop_d  = '0;
        if ((state_d == StRun) && start_vld_d && (cnt_d < PulseLen)) begin
            start_d[k_d] = 1'b1;
        end
        if ((state_d != StIdle) && stop_vld_d && (cnt_d < PulseLen)) begin
            stop_d[stop_k_d] = 1'b1;
        end
        busy_d = (state_d != StIdle);
    end

    // State and registered outputs; synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            win_q       <= WindowDefault;
            k_q         <= '0;
            stop_k_q    <= '0;
            start_vld_q <= 1'b0;
            stop_vld_q  <= 1'b0;
            oneshot_q   <= 1'b0;
            start_q     <= '0;
            stop_q      <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
`ifdef FREQ_ANALYZER_SEQ_RUNTIME_WINDOW_EN
            pend_q      <= '0;
            pend_vld_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            win_q       <= win_d;
            k_q         <= k_d;
            stop_k_q    <= stop_k_d;
            start_vld_q <= start_vld_d;
            stop_vld_q  <= stop_vld_d;
            oneshot_q   <= oneshot_d;
            start_q     <= start_d;
            stop_q      <= stop_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
`ifdef FREQ_ANALYZER_SEQ_RUNTIME_WINDOW_EN
            pend_q      <= pend_d;
            pend_vld_q  <= pend_vld_d;
`endif
        end
    end

    assign bus.start_analyzer = start_q;
    assign bus.stop_analyzer  = stop_q;
    assign bus.active_channel = k_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
endmodule

// File: tb/tb_frequency_analyzer_sequencer.sv
// Directed bench: 3-channel sequencer (W=100, PW=4) plus a 5-channel free run (W=20, PW=4).
// Time label t: inputs driven at negedge t are sampled by the following posedge;
// registered results of that edge are observed at negedge t+1.
module tb_frequency_analyzer_sequencer;
    logic clock = 1'b0;
    logic reset;
    logic reset5;
    int   t;
    int   errors = 0;
    int   checks = 0;

    always #5 clock = ~clock;

    frequency_analyzer_sequencer_if #(.CHANNELS(3), .COUNTER_WIDTH(32)) bus3 ();
    frequency_analyzer_sequencer_if #(.CHANNELS(5), .COUNTER_WIDTH(32)) bus5 ();

    frequency_analyzer_sequencer #(
        .CHANNELS(3), .CLOCK(1000), .FREQUENCY(10), .PULSE_WIDTH(4), .COUNTER_WIDTH(32)
    ) dut3 (
        .clock(clock),
        .reset(reset),
        .bus  (bus3)
    );

    frequency_analyzer_sequencer #(
        .CHANNELS(5), .CLOCK(1000), .FREQUENCY(50), .PULSE_WIDTH(4), .COUNTER_WIDTH(32)
    ) dut5 (
        .clock(clock),
        .reset(reset5),
        .bus  (bus5)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0d: got %0h expected %0h", tag, t, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
        t++;
    endtask

    task automatic go(input int c);
        while (t < c) step();
    endtask

    task automatic expect3(input string tag, input logic [2:0] st, input logic [2:0] sp,
                           input logic b);
        check({tag, ".start"}, 32'(bus3.start_analyzer), 32'(st));
        check({tag, ".stop"}, 32'(bus3.stop_analyzer), 32'(sp));
        check({tag, ".busy"}, 32'(bus3.busy), 32'(b));
    endtask

    task automatic restart();
        reset        = 1'b0;
        bus3.enable  = 1'b0;
        bus3.oneshot = 1'b0;
`ifdef FREQ_ANALYZER_SEQ_RUNTIME_WINDOW_EN
        bus3.window_load  = 1'b0;
        bus3.window_ticks = '0;
`endif
        repeat (3) @(negedge clock);
        reset = 1'b1;
        t     = 0;
    endtask

    int   starts5 [5];
    logic [4:0] prev5;
    logic overlap5;
    logic multi5;

    initial begin
        reset5       = 1'b0;
        bus5.enable  = 1'b0;
        bus5.oneshot = 1'b0;
`ifdef FREQ_ANALYZER_SEQ_RUNTIME_WINDOW_EN
        bus5.window_load  = 1'b0;
        bus5.window_ticks = '0;
`endif

        // Reset state and free-running rotation, then reset mid-pulse.
        restart();
        expect3("rst", 3'b000, 3'b000, 1'b0);
        check("rst.done", 32'(bus3.done), 32'd0);
        check("rst.active", 32'(bus3.active_channel), 32'd0);
        go(10); bus3.enable = 1'b1;
        go(11);  expect3("a11", 3'b001, 3'b000, 1'b1);
        go(14);  expect3("a14", 3'b001, 3'b000, 1'b1);
        go(15);  expect3("a15", 3'b000, 3'b000, 1'b1);
        go(111); expect3("a111", 3'b010, 3'b001, 1'b1);
        check("a111.active", 32'(bus3.active_channel), 32'd1);
        go(114); expect3("a114", 3'b010, 3'b001, 1'b1);
        go(115); expect3("a115", 3'b000, 3'b000, 1'b1);
        go(211); expect3("a211", 3'b100, 3'b010, 1'b1);
        check("a211.active", 32'(bus3.active_channel), 32'd2);
        go(311); expect3("a311", 3'b001, 3'b100, 1'b1);
        check("a311.active", 32'(bus3.active_channel), 32'd0);
        go(313); reset = 1'b0;
        go(314); expect3("rmid", 3'b000, 3'b000, 1'b0);
        check("rmid.done", 32'(bus3.done), 32'd0);
        reset = 1'b1;
        go(315); expect3("rrun", 3'b001, 3'b000, 1'b1);
        go(415); expect3("rrun415", 3'b010, 3'b001, 1'b1);

        // One-shot sweep.
        restart();
        bus3.oneshot = 1'b1;
        go(10); bus3.enable = 1'b1;
        go(11);  expect3("o11", 3'b001, 3'b000, 1'b1);
        go(211); expect3("o211", 3'b100, 3'b010, 1'b1);
        go(311); expect3("o311", 3'b000, 3'b100, 1'b1);
        check("o311.active", 32'(bus3.active_channel), 32'd2);
        go(312); bus3.enable = 1'b0;
        go(314); expect3("o314", 3'b000, 3'b100, 1'b1);
        check("o314.done", 32'(bus3.done), 32'd0);
        go(315); expect3("o315", 3'b000, 3'b000, 1'b0);
        check("o315.done", 32'(bus3.done), 32'd1);
        go(316); check("o316.done", 32'(bus3.done), 32'd0);
        go(411); expect3("o411", 3'b000, 3'b000, 1'b0);

        // Graceful stop; enable re-raised while stopping is ignored until idle.
        restart();
        go(10); bus3.enable = 1'b1;
        go(150); bus3.enable = 1'b0;
        go(151); expect3("s151", 3'b000, 3'b010, 1'b1);
        check("s151.active", 32'(bus3.active_channel), 32'd1);
        go(152); bus3.enable = 1'b1;
        go(154); expect3("s154", 3'b000, 3'b010, 1'b1);
        go(155); expect3("s155", 3'b000, 3'b000, 1'b0);
        check("s155.done", 32'(bus3.done), 32'd1);
        go(156); expect3("s156", 3'b001, 3'b000, 1'b1);
        check("s156.active", 32'(bus3.active_channel), 32'd0);

        // Enable dropped on a boundary edge: rotate first, then stop the new channel.
        restart();
        go(10); bus3.enable = 1'b1;
        go(110); bus3.enable = 1'b0;
        go(111); expect3("b111", 3'b010, 3'b001, 1'b1);
        go(112); expect3("b112", 3'b000, 3'b010, 1'b1);
        go(115); expect3("b115", 3'b000, 3'b010, 1'b1);
        go(116); expect3("b116", 3'b000, 3'b000, 1'b0);
        check("b116.done", 32'(bus3.done), 32'd1);

`ifdef FREQ_ANALYZER_SEQ_RUNTIME_WINDOW_EN
        // Runtime window: deferred to the boundary, clamped to PW+1, reset restores W0.
        restart();
        go(10); bus3.enable = 1'b1;
        go(60); bus3.window_ticks = 32'd50; bus3.window_load = 1'b1;
        go(61); bus3.window_load = 1'b0;
        go(111); expect3("w111", 3'b010, 3'b001, 1'b1);
        go(160); expect3("w160", 3'b000, 3'b000, 1'b1);
        go(161); expect3("w161", 3'b100, 3'b010, 1'b1);
        go(170); bus3.window_ticks = 32'd2; bus3.window_load = 1'b1;
        go(171); bus3.window_load = 1'b0;
        go(211); expect3("w211", 3'b001, 3'b100, 1'b1);
        go(215); expect3("w215", 3'b000, 3'b000, 1'b1);
        go(216); expect3("w216", 3'b010, 3'b001, 1'b1);
        go(221); expect3("w221", 3'b100, 3'b010, 1'b1);
        restart();
        go(10); bus3.enable = 1'b1;
        go(16);  expect3("wr16", 3'b000, 3'b000, 1'b1);
        go(111); expect3("wr111", 3'b010, 3'b001, 1'b1);
`endif

        // Five-channel free run for two full sweeps.
        restart();
        reset5 = 1'b1;
        for (int i = 0; i < 5; i++) starts5[i] = 0;
        prev5    = '0;
        overlap5 = 1'b0;
        multi5   = 1'b0;
        go(10); bus5.enable = 1'b1;
        while (t < 210) begin
            step();
            for (int i = 0; i < 5; i++) begin
                if (bus5.start_analyzer[i] && !prev5[i]) starts5[i]++;
            end
            if ((bus5.start_analyzer & bus5.stop_analyzer) != '0) overlap5 = 1'b1;
            if (!$onehot0(bus5.start_analyzer) || !$onehot0(bus5.stop_analyzer)) multi5 = 1'b1;
            prev5 = bus5.start_analyzer;
        end
        for (int i = 0; i < 5; i++) check($sformatf("f.starts%0d", i), 32'(starts5[i]), 32'd2);
        check("f.overlap", 32'(overlap5), 32'd0);
        check("f.onehot", 32'(multi5), 32'd0);
        go(211);
        check("f211.start", 32'(bus5.start_analyzer), 32'h01);
        check("f211.stop", 32'(bus5.stop_analyzer), 32'h10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
